ci_dma_engine: RTL

- DMA engine that drives port B of the custom-instruction scratch SSRAM (512 x 32).
- Moves blocks between the shared system bus and that SSRAM in bursts, as a bus master.
- Configured and polled through a register interface decoded upstream from custom-instruction accesses with valueA[12:10] != 0.
- Sits between the CI decoder/SSRAM and the bus arbiter.

---
 rtl/ci_dma_engine.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ci_dma_engine.sv
// rtl/ci_dma_engine.sv - burst DMA between the system bus and CI scratch SSRAM port B
// Optional feature macro: DMA_IRQ_EN (sticky done flag, irq output, status bit2).
module ci_dma_engine #(
    parameter int MAX_BURST_BEATS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cfgWrite,
    input  logic [2:0]  cfgSel,
    input  logic [31:0] cfgData,
    output logic [31:0] cfgReadData,
    output logic [8:0]  memAddress,
    output logic        memWriteEnable,
    output logic [31:0] memWriteData,
    input  logic [31:0] memReadData,
    output logic        requestBus,
    input  logic        busGrant,
    output logic        beginTransaction,
    output logic [31:0] addressDataOut,
    output logic [3:0]  byteEnables,
    output logic        readNotWrite,
    output logic [7:0]  burstSize,
    output logic        dataValidOut,
    output logic        endTransactionOut,
    input  logic [31:0] addressDataIn,
    input  logic        dataValidIn,
    input  logic        busyIn,
    input  logic        endTransactionIn,
    input  logic        errorIn
`ifdef DMA_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST_BEATS);

    typedef enum logic [2:0] {
        IDLE, REQUEST, BEGIN, READ, WRITE, END, ERROR
    } state_t;

    state_t      state;

    logic [29:0] bus_addr_reg;
    logic [8:0]  mem_addr_reg;
    logic [9:0]  block_reg;
    logic [7:0]  burst_reg;
    logic        error_flag;
`ifdef DMA_IRQ_EN
    logic        done_flag;
`endif

    logic [29:0] work_bus;
    logic [8:0]  work_mem;
    logic [9:0]  remaining;
    logic [8:0]  beats_left;
    logic        dir_read;

    logic        request_r;
    logic        begin_r;
    logic        end_r;
    logic        rnw_r;
    logic [3:0]  be_r;
    logic [7:0]  burst_r;
    logic [31:0] addr_r;

    logic        busy;
    logic        cfg_accept;
    logic        start_any;
    logic        beat;
    logic [9:0]  rem_after;
    logic [29:0] work_bus_next;
    logic [8:0]  burst_beats;
    logic [8:0]  chunk;
    logic        launch;
    logic        requeue;
    logic        finish;
    logic        err_hit;
    logic [7:0]  wr_burst;
    logic [9:0]  wr_block;

    assign busy          = (state != IDLE);
    assign cfg_accept    = cfgWrite && !busy;
    assign start_any     = cfg_accept && (cfgSel == 3'd5) && (cfgData[1:0] != 2'b00)
                           && (block_reg != 10'd0);
    assign beat          = ((state == READ) && dataValidIn) || ((state == WRITE) && !busyIn);
    assign rem_after     = remaining - 10'(beat);
    assign work_bus_next = work_bus + 30'(beat);
    assign burst_beats   = {1'b0, burst_reg} + 9'd1;
    // A burst never exceeds what is left of the block.
    assign chunk         = (rem_after < {1'b0, burst_beats}) ? rem_after[8:0] : burst_beats;

    assign launch  = ((state == REQUEST) && busGrant)
                  || ((state == READ) && endTransactionIn && (rem_after != 10'd0) && busGrant)
                  || ((state == END) && (remaining != 10'd0) && busGrant);
    assign requeue = ((state == READ) && endTransactionIn && (rem_after != 10'd0) && !busGrant)
                  || ((state == END) && (remaining != 10'd0) && !busGrant);
    assign finish  = ((state == READ) && endTransactionIn && (rem_after == 10'd0))
                  || ((state == END) && (remaining == 10'd0));
    assign err_hit = errorIn && (state != IDLE) && (state != ERROR);

    assign wr_burst = ({1'b0, cfgData[7:0]} >= MAX_BEATS) ? 8'(MAX_BEATS - 9'd1) : cfgData[7:0];
    assign wr_block = (cfgData > 32'd512) ? 10'd512 : cfgData[9:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            bus_addr_reg <= '0;
            mem_addr_reg <= '0;
            block_reg    <= '0;
            burst_reg    <= '0;
            error_flag   <= 1'b0;
`ifdef DMA_IRQ_EN
            done_flag    <= 1'b0;
`endif
            work_bus     <= '0;
            work_mem     <= '0;
            remaining    <= '0;
            beats_left   <= '0;
            dir_read     <= 1'b0;
            request_r    <= 1'b0;
            begin_r      <= 1'b0;
            end_r        <= 1'b0;
            rnw_r        <= 1'b0;
            be_r         <= '0;
            burst_r      <= '0;
            addr_r       <= '0;
        end else begin
            begin_r <= 1'b0;
            end_r   <= 1'b0;

            if (cfg_accept) begin
                case (cfgSel)
                    3'd1:    bus_addr_reg <= cfgData[31:2];
                    3'd2:    mem_addr_reg <= cfgData[8:0];
                    3'd3:    block_reg    <= wr_block;
                    3'd4:    burst_reg    <= wr_burst;
                    default: ;
                endcase
            end
`ifdef DMA_IRQ_EN
            if (cfgWrite && (cfgSel == 3'd5) && cfgData[2])
                done_flag <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (start_any) begin
                        dir_read   <= cfgData[0];
                        work_bus   <= bus_addr_reg;
                        work_mem   <= mem_addr_reg;
                        remaining  <= block_reg;
                        error_flag <= 1'b0;
                        request_r  <= 1'b1;
                        state      <= REQUEST;
                    end
                end
                BEGIN: begin
                    addr_r <= '0;
                    state  <= dir_read ? READ : WRITE;
                end
                READ, WRITE: begin
                    if (beat) begin
                        work_mem  <= work_mem + 9'd1;
                        work_bus  <= work_bus_next;
                        remaining <= rem_after;
                        if (state == WRITE) begin
                            beats_left <= beats_left - 9'd1;
                            if (beats_left == 9'd1) begin
                                end_r <= 1'b1;
                                state <= END;
                            end
                        end
                    end
                end
                ERROR:   state <= IDLE;
                default: ;
            endcase

            if (launch) begin
                state      <= BEGIN;
                request_r  <= 1'b1;
                begin_r    <= 1'b1;
                addr_r     <= {work_bus_next, 2'b00};
                burst_r    <= 8'(chunk - 9'd1);
                beats_left <= chunk;
                rnw_r      <= dir_read;
                be_r       <= 4'hF;
            end
            if (requeue) begin
                state   <= REQUEST;
                rnw_r   <= 1'b0;
                be_r    <= '0;
                burst_r <= '0;
            end
            if (finish) begin
                state     <= IDLE;
                request_r <= 1'b0;
                rnw_r     <= 1'b0;
                be_r      <= '0;
                burst_r   <= '0;
`ifdef DMA_IRQ_EN
                done_flag <= 1'b1;
`endif
            end
            // Errors abort the whole block; leftover words are dropped.
            if (err_hit) begin
                state      <= ERROR;
                error_flag <= 1'b1;
                request_r  <= 1'b0;
                begin_r    <= 1'b0;
                end_r      <= 1'b0;
                rnw_r      <= 1'b0;
                be_r       <= '0;
                burst_r    <= '0;
                addr_r     <= '0;
`ifdef DMA_IRQ_EN
                done_flag  <= 1'b1;
`endif
            end
        end
    end

    always_comb begin
        cfgReadData = '0;
        case (cfgSel)
            3'd1: cfgReadData = {bus_addr_reg, 2'b00};
            3'd2: cfgReadData = {23'd0, mem_addr_reg};
            3'd3: cfgReadData = {22'd0, block_reg};
            3'd4: cfgReadData = {24'd0, burst_reg};
`ifdef DMA_IRQ_EN
            3'd5: cfgReadData = {29'd0, done_flag, error_flag, busy};
`else
            3'd5: cfgReadData = {30'd0, error_flag, busy};
`endif
            default: cfgReadData = '0;
        endcase
    end

`ifdef DMA_IRQ_EN
    assign irq = done_flag;
`endif

    assign memAddress        = work_mem;
    assign memWriteEnable    = (state == READ) && dataValidIn;
    assign memWriteData      = memWriteEnable ? addressDataIn : 32'd0;
    assign requestBus        = request_r;
    assign beginTransaction  = begin_r;
    assign endTransactionOut = end_r;
    assign readNotWrite      = rnw_r;
    assign byteEnables       = be_r;
    assign burstSize         = burst_r;
    // SSRAM read data arrives in the same cycle, so write beats bypass the output register.
    assign dataValidOut      = (state == WRITE);
    assign addressDataOut    = (state == WRITE) ? memReadData : addr_r;

endmodule
